serial_mem_target: RTL and testbench



---
 rtl/serial_bus_pkg.sv | 27 ++
 rtl/serial_mem_target_if.sv | 33 +++
 rtl/serial_shift_rx.sv | 36 +++
 rtl/serial_mem_target.sv | 209 ++++++++++++++++++++
 tb/tb_serial_mem_target.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus target: default field widths,
// mode and rw encodings on the serial lines, and the target FSM state type.
// No ports; imported by the target top and its interface users.
package serial_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // bus_mode encoding
  localparam logic MODE_ADDR = 1'b1;
  localparam logic MODE_DATA = 1'b0;

  // bus_init_rw / bus_target_rw encoding
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SEL,
    ST_WDATA,
    ST_WRITE,
    ST_RWAIT,
    ST_RDATA
  } tgt_state_t;

endpackage

// File: rtl/serial_mem_target_if.sv
// Serial bus bundle between the initiator side (plus address decoder) and
// one target. master: initiator/decoder drives serial in, mode, rw, ready,
// decoder_valid. slave: target drives serial out and its status strobes.
interface serial_mem_target_if;

  logic bus_data_in;
  logic bus_data_in_valid;
  logic bus_mode;
  logic bus_init_rw;
  logic bus_init_ready;
  logic decoder_valid;
  logic bus_data_out;
  logic bus_data_out_valid;
  logic bus_target_ready;
  logic bus_target_rw;
  logic bus_target_ack;
  logic bus_target_err;

  modport master (
    output bus_data_in, bus_data_in_valid, bus_mode, bus_init_rw,
           bus_init_ready, decoder_valid,
    input  bus_data_out, bus_data_out_valid, bus_target_ready,
           bus_target_rw, bus_target_ack, bus_target_err
  );

  modport slave (
    input  bus_data_in, bus_data_in_valid, bus_mode, bus_init_rw,
           bus_init_ready, decoder_valid,
    output bus_data_out, bus_data_out_valid, bus_target_ready,
           bus_target_rw, bus_target_ack, bus_target_err
  );

endinterface

// File: rtl/serial_shift_rx.sv
// LSB-first serial-to-parallel capture: bit counter plus shift register.
// Ports: clk/rst_n, clear (restart count), load (take bit_in this cycle),
// bit_in; data (captured field), done (this load completes WIDTH bits).
module serial_shift_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;

  // clear and load together start a new field with its first bit
  assign cnt_base = clear ? '0 : cnt;
  assign done     = load && (cnt_base == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      data <= '0;
    end else begin
      cnt <= load ? cnt_base + 1'b1 : cnt_base;
      // new bits enter at the top so the first bit ends up in bit 0
      if (load) data <= {bit_in, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_mem_target.sv
// Serial bus target fused with a byte-wide register memory: captures address
// and write data, writes memory or serializes the addressed byte back.
// Ports: clk, rst_n, sbus (slave side). Macro SERIAL_MEM_TARGET_RANGE_CHECK_EN
// enables out-of-range detection (err pulse, dropped write, zero read data).
module serial_mem_target
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = 256,
  parameter int READ_LAT  = 2,
  parameter int DEC_WAIT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_mem_target_if.slave  sbus
);

  localparam int OFF_W  = $clog2(MEM_DEPTH);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int WAIT_W = $clog2((DEC_WAIT > 1) ? DEC_WAIT : 2);

  tgt_state_t state;

  logic              dout_q, dout_vld_q, ready_q, rw_q, ack_q, err_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        lat_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rd_shift;

  logic              addr_load, addr_clear, addr_done;
  logic [ADDR_W-1:0] addr_q;
  logic              data_load, data_clear, data_done;
  logic [DATA_W-1:0] data_q;

  logic [OFF_W-1:0]  offset;
  logic              out_of_range;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] mem_rd;
  logic              lat_done, rd_go;

  // Address bits are taken in IDLE (first bit) and ADDR only.
  assign addr_clear = (state == ST_IDLE);
  assign addr_load  = sbus.bus_data_in_valid && (sbus.bus_mode == MODE_ADDR) &&
                      ((state == ST_IDLE) || (state == ST_ADDR));

  assign data_clear = (state != ST_WDATA);
  assign data_load  = (state == ST_WDATA) && sbus.bus_data_in_valid &&
                      (sbus.bus_mode == MODE_DATA);

  serial_shift_rx #(.WIDTH(ADDR_W)) u_addr_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (addr_clear),
    .load   (addr_load),
    .bit_in (sbus.bus_data_in),
    .data   (addr_q),
    .done   (addr_done)
  );

  serial_shift_rx #(.WIDTH(DATA_W)) u_data_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (data_clear),
    .load   (data_load),
    .bit_in (sbus.bus_data_in),
    .data   (data_q),
    .done   (data_done)
  );

`ifdef SERIAL_MEM_TARGET_RANGE_CHECK_EN
  // Bits above the offset but below the top nibble must be zero; the top
  // nibble belongs to the address decoder.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_W-1:0] NIB_MASK = ADDR_W'((64'd1 << (ADDR_W - 4)) - 64'd1);
  localparam logic [ADDR_W-1:0] MID_MASK = NIB_MASK & ~LOW_MASK;

  assign offset       = addr_q[OFF_W-1:0];
  assign out_of_range = ({1'b0, offset} >= (OFF_W + 1)'(MEM_DEPTH)) ||
                        (|(addr_q & MID_MASK));
`else
  assign offset       = OFF_W'(32'(addr_q) % MEM_DEPTH);
  assign out_of_range = 1'b0;
`endif

  assign mem_rd = out_of_range ? '0 : mem[offset];

  // Memory is not reset; writes happen only in the single WRITE cycle, so an
  // interrupted transaction can never commit.
  always_ff @(posedge clk) begin
    if ((state == ST_WRITE) && !out_of_range) mem[offset] <= data_q;
  end

  // Read latency elapsed once READ_LAT wait cycles have been spent in RWAIT.
  assign lat_done = (32'(lat_cnt) + 32'd1 >= 32'(READ_LAT));

  // First read bit launches either straight from SEL (zero latency) or from
  // RWAIT after the latency; both wait for the initiator to be ready.
  assign rd_go = sbus.bus_init_ready &&
                 (((state == ST_SEL) && sbus.decoder_valid && (rw_q == RW_READ) &&
                   (READ_LAT == 0)) ||
                  ((state == ST_RWAIT) && lat_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      rw_q       <= RW_READ;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      lat_cnt    <= '0;
      bit_cnt    <= '0;
      rd_shift   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (rd_go) begin
        state      <= ST_RDATA;
        dout_q     <= mem_rd[0];
        dout_vld_q <= 1'b1;
        rd_shift   <= mem_rd >> 1;
        bit_cnt    <= BIT_W'(1);
        err_q      <= out_of_range;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sbus.bus_data_in_valid && (sbus.bus_mode == MODE_ADDR)) begin
              rw_q     <= sbus.bus_init_rw;
              ready_q  <= 1'b0;
              wait_cnt <= '0;
              state    <= addr_done ? ST_SEL : ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (sbus.bus_data_in_valid) begin
              if (sbus.bus_mode != MODE_ADDR) begin
                state   <= ST_IDLE;
                ready_q <= 1'b1;
              end else if (addr_done) begin
                state    <= ST_SEL;
                wait_cnt <= '0;
              end
            end
          end
          ST_SEL: begin
            if (sbus.decoder_valid) begin
              lat_cnt <= '0;
              state   <= (rw_q == RW_WRITE) ? ST_WDATA : ST_RWAIT;
            end else if (32'(wait_cnt) + 32'd1 >= 32'(DEC_WAIT)) begin
              // another target owns this address
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_WDATA: begin
            if (sbus.bus_data_in_valid && (sbus.bus_mode == MODE_ADDR)) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end else if (data_done) begin
              state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            if (out_of_range) err_q <= 1'b1;
            else              ack_q <= 1'b1;
          end
          ST_RWAIT: begin
            if (!lat_done) lat_cnt <= lat_cnt + 4'd1;
          end
          ST_RDATA: begin
            if (32'(bit_cnt) >= 32'(DATA_W)) begin
              state      <= ST_IDLE;
              ready_q    <= 1'b1;
              dout_q     <= 1'b0;
              dout_vld_q <= 1'b0;
            end else if (sbus.bus_init_ready) begin
              dout_q     <= rd_shift[0];
              rd_shift   <= rd_shift >> 1;
              bit_cnt    <= bit_cnt + 1'b1;
              dout_vld_q <= 1'b1;
            end else begin
              // initiator stalled: hold position, resume on the next bit
              dout_vld_q <= 1'b0;
            end
          end
          default: begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sbus.bus_data_out       = dout_q;
  assign sbus.bus_data_out_valid = dout_vld_q;
  assign sbus.bus_target_ready   = ready_q;
  assign sbus.bus_target_rw      = rw_q;
  assign sbus.bus_target_ack     = ack_q;
  assign sbus.bus_target_err     = err_q;

endmodule

// File: tb/tb_serial_mem_target.sv
// Bench for serial_mem_target: directed scenarios plus randomized traffic,
// checked against a byte-array memory model and cycle-count expectations.
module tb_serial_mem_target;
  import serial_bus_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int RL    = 2;
  localparam int DWT   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  serial_mem_target_if bus_if ();

  serial_mem_target #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .READ_LAT(RL), .DEC_WAIT(DWT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sbus (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: anything below the decoder nibble beyond the memory is out of range
  function automatic bit is_oor(input logic [15:0] a);
`ifdef SERIAL_MEM_TARGET_RANGE_CHECK_EN
    return (int'(a) % 4096) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int slot(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic send_addr(input logic [15:0] a, input logic rw, input int gap_at);
    for (int i = 0; i < AW; i++) begin
      if (i == gap_at) begin
        bus_if.bus_data_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("addr_gap_busy", 32'(bus_if.bus_target_ready), 32'd0);
      end
      bus_if.bus_mode          = MODE_ADDR;
      bus_if.bus_init_rw       = rw;
      bus_if.bus_data_in       = a[i];
      bus_if.bus_data_in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.bus_data_in_valid = 1'b0;
    check("rw_latched", 32'(bus_if.bus_target_rw), 32'(rw));
  endtask

  // Decoder selects after dly SEL cycles; junk serial traffic meanwhile.
  task automatic select(input int dly);
    for (int j = 0; j <= dly; j++) begin
      bus_if.decoder_valid     = (j == dly);
      bus_if.bus_data_in_valid = 1'($urandom);
      bus_if.bus_data_in       = 1'($urandom);
      bus_if.bus_mode          = 1'($urandom);
      @(negedge clk);
    end
    bus_if.decoder_valid     = 1'b0;
    bus_if.bus_data_in_valid = 1'b0;
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [7:0] d, input int dly,
                           input int gap_at, input bit rand_gaps);
    bit oor;
    oor = is_oor(a);
    check("wr_ready", 32'(bus_if.bus_target_ready), 32'd1);
    send_addr(a, RW_WRITE, gap_at);
    select(dly);
    for (int i = 0; i < DW; i++) begin
      if (rand_gaps && ($urandom_range(0, 3) == 0)) begin
        bus_if.bus_data_in_valid = 1'b0;
        @(negedge clk);
      end
      bus_if.bus_mode          = MODE_DATA;
      bus_if.bus_data_in       = d[i];
      bus_if.bus_data_in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.bus_data_in_valid = 1'b0;
    check("wr_ack_early", 32'(bus_if.bus_target_ack), 32'd0);
    check("wr_busy", 32'(bus_if.bus_target_ready), 32'd0);
    check("wr_no_rdata", 32'(bus_if.bus_data_out_valid), 32'd0);
    @(negedge clk);
    check("wr_ack", 32'(bus_if.bus_target_ack), 32'(!oor));
    check("wr_err", 32'(bus_if.bus_target_err), 32'(oor));
    check("wr_done_ready", 32'(bus_if.bus_target_ready), 32'd1);
    if (!oor) ref_mem[slot(a)] = d;
  endtask

  // drop_mode: 0 ready held, 1 two-cycle stall mid byte, 2 random stalls
  task automatic read_txn(input logic [15:0] a, input int dly, input int gap_at,
                          input int drop_mode);
    bit         oor;
    logic [7:0] exp;
    logic [7:0] got;
    int         n;
    oor = is_oor(a);
    exp = oor ? 8'h00 : ref_mem[slot(a)];
    got = 8'h00;
    n   = 0;
    check("rd_ready", 32'(bus_if.bus_target_ready), 32'd1);
    send_addr(a, RW_READ, gap_at);
    select(dly);
    for (int j = 0; j < RL; j++) begin
      check("rd_lat_quiet", 32'(bus_if.bus_data_out_valid), 32'd0);
      @(negedge clk);
    end
    check("rd_first_bit", 32'(bus_if.bus_data_out_valid), 32'd1);
    check("rd_err", 32'(bus_if.bus_target_err), 32'(oor));
    for (int c = 0; c < 8 * DW && n < DW; c++) begin
      check("rd_no_ack", 32'(bus_if.bus_target_ack), 32'd0);
      if (bus_if.bus_data_out_valid) begin
        got = {bus_if.bus_data_out, got[7:1]};
        n++;
      end
      case (drop_mode)
        1:       bus_if.bus_init_ready = !((c == 3) || (c == 4));
        2:       bus_if.bus_init_ready = ($urandom_range(0, 2) != 0);
        default: bus_if.bus_init_ready = 1'b1;
      endcase
      @(negedge clk);
    end
    bus_if.bus_init_ready = 1'b1;
    check("rd_bits", 32'(n), 32'(DW));
    check("rd_byte", 32'(got), 32'(exp));
    check("rd_end_valid", 32'(bus_if.bus_data_out_valid), 32'd0);
    check("rd_end_ready", 32'(bus_if.bus_target_ready), 32'd1);
  endtask

  task automatic timeout_txn(input logic [15:0] a, input logic rw);
    check("to_start_ready", 32'(bus_if.bus_target_ready), 32'd1);
    send_addr(a, rw, -1);
    for (int j = 0; j < DWT; j++) begin
      check("to_busy", 32'(bus_if.bus_target_ready), 32'd0);
      check("to_quiet", 32'(bus_if.bus_data_out_valid), 32'd0);
      @(negedge clk);
    end
    check("to_ready", 32'(bus_if.bus_target_ready), 32'd1);
    check("to_no_ack", 32'(bus_if.bus_target_ack), 32'd0);
    check("to_no_rdata", 32'(bus_if.bus_data_out_valid), 32'd0);
  endtask

  // Address phase cut short by a data-mode bit
  task automatic abort_addr(input logic [15:0] a, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus_if.bus_mode          = MODE_ADDR;
      bus_if.bus_init_rw       = RW_WRITE;
      bus_if.bus_data_in       = a[i];
      bus_if.bus_data_in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.bus_mode = MODE_DATA;
    @(negedge clk);
    bus_if.bus_data_in_valid = 1'b0;
    check("abort_addr_ready", 32'(bus_if.bus_target_ready), 32'd1);
  endtask

  // Write data phase cut short by an address-mode bit; memory must not change
  task automatic abort_wdata(input logic [15:0] a);
    send_addr(a, RW_WRITE, -1);
    select(0);
    for (int i = 0; i < 3; i++) begin
      bus_if.bus_mode          = MODE_DATA;
      bus_if.bus_data_in       = 1'b1;
      bus_if.bus_data_in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.bus_mode = MODE_ADDR;
    @(negedge clk);
    bus_if.bus_data_in_valid = 1'b0;
    check("abort_wd_ready", 32'(bus_if.bus_target_ready), 32'd1);
    @(negedge clk);
    check("abort_wd_no_ack", 32'(bus_if.bus_target_ack), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  mid;
    int          kind, dly, gap;

    bus_if.bus_data_in       = 1'b0;
    bus_if.bus_data_in_valid = 1'b0;
    bus_if.bus_mode          = MODE_DATA;
    bus_if.bus_init_rw       = RW_READ;
    bus_if.bus_init_ready    = 1'b1;
    bus_if.decoder_valid     = 1'b0;

    @(negedge clk);
    check("rst_ready", 32'(bus_if.bus_target_ready), 32'd1);
    check("rst_dout", 32'(bus_if.bus_data_out), 32'd0);
    check("rst_dout_vld", 32'(bus_if.bus_data_out_valid), 32'd0);
    check("rst_rw", 32'(bus_if.bus_target_rw), 32'd0);
    check("rst_ack", 32'(bus_if.bus_target_ack), 32'd0);
    check("rst_err", 32'(bus_if.bus_target_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // give every memory byte a known value
    for (int i = 0; i < DEPTH; i++) write_txn(16'h8000 + 16'(i), 8'($urandom), 0, -1, 1'b0);

    write_txn(16'h800A, 8'h5C, 1, -1, 1'b0);
    read_txn(16'h800A, 0, -1, 0);
    timeout_txn(16'h800A, RW_READ);
    write_txn(16'h8005, 8'hA7, 0, -1, 1'b0);
    read_txn(16'h8005, 2, 7, 1);

    // reset in the middle of the data phase of a write
    send_addr(16'h8001, RW_WRITE, -1);
    select(0);
    for (int i = 0; i < 3; i++) begin
      bus_if.bus_mode          = MODE_DATA;
      bus_if.bus_data_in       = 1'b1;
      bus_if.bus_data_in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.bus_data_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus_if.bus_target_ready), 32'd1);
    check("mid_rst_rw", 32'(bus_if.bus_target_rw), 32'd0);
    check("mid_rst_ack", 32'(bus_if.bus_target_ack), 32'd0);
    check("mid_rst_dvld", 32'(bus_if.bus_data_out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_txn(16'h8001, 0, -1, 0);

    // address bits between the offset and the decoder nibble
    write_txn(16'h8020, 8'h3C, 0, -1, 1'b0);
    read_txn(16'h8000, 0, -1, 0);
    read_txn(16'h8020, 1, -1, 0);

    abort_addr(16'h8003, 5);
    abort_wdata(16'h8003);
    read_txn(16'h8003, 0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      mid  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      a    = {4'h8, mid, 4'($urandom)};
      kind = $urandom_range(0, 9);
      dly  = $urandom_range(0, DWT - 1);
      gap  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, AW - 1) : -1;
      if (kind < 4)       write_txn(a, 8'($urandom), dly, gap, 1'b1);
      else if (kind < 8)  read_txn(a, dly, gap, 2);
      else if (kind == 8) timeout_txn(a, 1'($urandom));
      else repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
